// File: rtl/wshb_arbiter.sv
// Two-master Wishbone B4 pipelined arbiter in front of a single SDRAM slave port.
// M0 (video reader) and M1 (framebuffer writer) share the slave; grant is held until all acks return.
module wshb_arbiter #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned OUT_W = 4,
  parameter bit          RR    = 1'b0
) (
  input  logic              wshb_clk,
  input  logic              wshb_rst_n,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [AW-1:0]     m0_adr,
  input  logic [DW-1:0]     m0_dat_ms,
  input  logic [DW/8-1:0]   m0_sel,
  output logic              m0_ack,
  output logic              m0_stall,
  output logic [DW-1:0]     m0_dat_sm,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [AW-1:0]     m1_adr,
  input  logic [DW-1:0]     m1_dat_ms,
  input  logic [DW/8-1:0]   m1_sel,
  output logic              m1_ack,
  output logic              m1_stall,
  output logic [DW-1:0]     m1_dat_sm,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [AW-1:0]     s_adr,
  output logic [DW-1:0]     s_dat_ms,
  output logic [DW/8-1:0]   s_sel,
  input  logic              s_ack,
  input  logic              s_stall,
  input  logic [DW-1:0]     s_dat_sm,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [OUT_W-1:0] CNT_MAX = '1;
  localparam logic [OUT_W-1:0] CNT_ONE = OUT_W'(1);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;

  logic own0, own1, cnt_nz, cnt_full;
  logic owner_cyc, owner_stb, accept, ack_ok, pick1, release_ok;

  always_comb begin
    own0      = (state_q == GNT0);
    own1      = (state_q == GNT1);
    cnt_nz    = (out_cnt_q != '0);
    cnt_full  = (out_cnt_q == CNT_MAX);
    owner_cyc = (own0 & m0_cyc) | (own1 & m1_cyc);
    owner_stb = (own0 & m0_stb) | (own1 & m1_stb);

    s_cyc    = owner_cyc | cnt_nz;
    s_stb    = owner_stb & ~cnt_full;
    s_we     = own1 ? m1_we     : m0_we;
    s_adr    = own1 ? m1_adr    : m0_adr;
    s_dat_ms = own1 ? m1_dat_ms : m0_dat_ms;
    s_sel    = own1 ? m1_sel    : m0_sel;

    accept = s_stb & ~s_stall;
    // An ack with nothing outstanding belongs to no one and is dropped.
    ack_ok = s_ack & cnt_nz;

    m0_ack    = own0 & ack_ok;
    m1_ack    = own1 & ack_ok;
    m0_stall  = ~own0 | s_stall | cnt_full;
    m1_stall  = ~own1 | s_stall | cnt_full;
    m0_dat_sm = s_dat_sm;
    m1_dat_sm = s_dat_sm;
    owner     = {own1, own0};

    out_cnt_d = out_cnt_q;
    if (accept && !ack_ok) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
    end else if (!accept && ack_ok) begin
      out_cnt_d = out_cnt_q - CNT_ONE;
    end

    if (m0_cyc && m1_cyc) begin
      pick1 = RR & ~last_q;
    end else begin
      pick1 = m1_cyc;
    end

    // IDLE has no owner cycle and no outstanding beats, so it always re-arbitrates.
    release_ok = ~owner_cyc & ~cnt_nz;
    state_d    = state_q;
    last_d     = last_q;
    if (release_ok) begin
      if (m0_cyc || m1_cyc) begin
        state_d = pick1 ? GNT1 : GNT0;
        last_d  = pick1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: one fixed-priority instance (OUT_W=2) and one round-robin instance.
// A latency-programmable slave model acks accepted strobes; grants, routing and counter limits are checked.
module tb_wshb_arbiter;

  logic clk;
  logic rst_n;
  logic use_rr;

  logic [1:0]       m_cyc, m_stb, m_we;
  logic [1:0][31:0] m_adr, m_dat;
  logic [1:0][3:0]  m_sel;

  logic        s_ack, s_stall, force_ack;
  logic [31:0] s_dat_sm;

  logic [1:0]       fp_ack, fp_stall, fp_owner, rr_ack, rr_stall, rr_owner;
  logic [1:0][31:0] fp_dsm, rr_dsm;
  logic             fp_s_cyc, fp_s_stb, fp_s_we, rr_s_cyc, rr_s_stb, rr_s_we;
  logic [31:0]      fp_s_adr, fp_s_dat, rr_s_adr, rr_s_dat;
  logic [3:0]       fp_s_sel, rr_s_sel;

  logic [1:0]       cur_ack, cur_stall, cur_owner;
  logic             cur_s_cyc, cur_s_stb, cur_s_we;
  logic [31:0]      cur_s_adr, cur_s_dat;
  logic [3:0]       cur_s_sel;
  logic [1:0][31:0] cur_dsm;

  int vectors     = 0;
  int miscompares = 0;
  int beat_err    = 0;
  int slave_lat   = 1;
  int m0_acks_seen = 0;
  int m1_acks_seen = 0;

  logic [7:0] ack_pipe;
  logic       rec_en = 1'b0;
  logic [1:0] prev_owner = 2'b00;
  logic [1:0] own_log [$];

  wshb_arbiter #(.AW(32), .DW(32), .OUT_W(2), .RR(1'b0)) u_fp (
    .wshb_clk(clk), .wshb_rst_n(rst_n),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
    .m0_dat_ms(m_dat[0]), .m0_sel(m_sel[0]), .m0_ack(fp_ack[0]), .m0_stall(fp_stall[0]),
    .m0_dat_sm(fp_dsm[0]),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
    .m1_dat_ms(m_dat[1]), .m1_sel(m_sel[1]), .m1_ack(fp_ack[1]), .m1_stall(fp_stall[1]),
    .m1_dat_sm(fp_dsm[1]),
    .s_cyc(fp_s_cyc), .s_stb(fp_s_stb), .s_we(fp_s_we), .s_adr(fp_s_adr),
    .s_dat_ms(fp_s_dat), .s_sel(fp_s_sel), .s_ack(s_ack), .s_stall(s_stall),
    .s_dat_sm(s_dat_sm), .owner(fp_owner)
  );

  wshb_arbiter #(.AW(32), .DW(32), .OUT_W(4), .RR(1'b1)) u_rr (
    .wshb_clk(clk), .wshb_rst_n(rst_n),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
    .m0_dat_ms(m_dat[0]), .m0_sel(m_sel[0]), .m0_ack(rr_ack[0]), .m0_stall(rr_stall[0]),
    .m0_dat_sm(rr_dsm[0]),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
    .m1_dat_ms(m_dat[1]), .m1_sel(m_sel[1]), .m1_ack(rr_ack[1]), .m1_stall(rr_stall[1]),
    .m1_dat_sm(rr_dsm[1]),
    .s_cyc(rr_s_cyc), .s_stb(rr_s_stb), .s_we(rr_s_we), .s_adr(rr_s_adr),
    .s_dat_ms(rr_s_dat), .s_sel(rr_s_sel), .s_ack(s_ack), .s_stall(s_stall),
    .s_dat_sm(s_dat_sm), .owner(rr_owner)
  );

  assign cur_ack   = use_rr ? rr_ack   : fp_ack;
  assign cur_stall = use_rr ? rr_stall : fp_stall;
  assign cur_owner = use_rr ? rr_owner : fp_owner;
  assign cur_s_cyc = use_rr ? rr_s_cyc : fp_s_cyc;
  assign cur_s_stb = use_rr ? rr_s_stb : fp_s_stb;
  assign cur_s_we  = use_rr ? rr_s_we  : fp_s_we;
  assign cur_s_adr = use_rr ? rr_s_adr : fp_s_adr;
  assign cur_s_dat = use_rr ? rr_s_dat : fp_s_dat;
  assign cur_s_sel = use_rr ? rr_s_sel : fp_s_sel;
  assign cur_dsm   = use_rr ? rr_dsm   : fp_dsm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave answers every accepted strobe exactly slave_lat cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_pipe <= '0;
    else        ack_pipe <= {ack_pipe[6:0], cur_s_stb & ~s_stall};
  end
  assign s_ack = ack_pipe[slave_lat-1] | force_ack;

  always @(negedge clk) begin
    if (cur_ack[0]) m0_acks_seen <= m0_acks_seen + 1;
    if (cur_ack[1]) m1_acks_seen <= m1_acks_seen + 1;
    if (rec_en) begin
      if (cur_owner != prev_owner && cur_owner != 2'b00) own_log.push_back(cur_owner);
      prev_owner <= cur_owner;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0; m_cyc = '0; m_stb = '0; force_ack = 1'b0; s_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives one pipelined burst of n beats on master m and waits for all its acks.
  task automatic applyStimulus(input int m, input int n, input logic we,
                               input logic [31:0] base, output int n_acks);
    int sent;
    int acks;
    sent = 0;
    acks = 0;
    m_we[m]  = we;
    m_adr[m] = base;
    m_dat[m] = base ^ 32'h5A5A_0000;
    m_sel[m] = (m == 1) ? 4'hC : 4'h3;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    for (int c = 0; c < 200 && acks < n; c++) begin
      @(negedge clk);
      if (m_stb[m] && !cur_stall[m]) begin
        if (cur_s_adr != base + 32'(4 * sent) || cur_s_we != we || cur_s_sel != m_sel[m] ||
            cur_s_dat != m_dat[m]) beat_err++;
        sent++;
      end
      if (cur_ack[m]) acks++;
      @(posedge clk); #1;
      if (sent == n) begin
        m_stb[m] = 1'b0;
      end else begin
        m_adr[m] = base + 32'(4 * sent);
        m_dat[m] = m_adr[m] ^ 32'h5A5A_0000;
      end
    end
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
    n_acks = acks;
  endtask

  initial begin
    int a0, a1, b0, b1, sent, acks, stall_seen, held_err;
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};

    use_rr = 1'b0; rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0; s_stall = 1'b0; force_ack = 1'b0;
    s_dat_sm = 32'hA5A5_3C3C;

    // T1: reset values, then idle with no requests
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_owner", 32'(cur_owner), 32'h0);
    checkOutput("rst_s_cyc", 32'(cur_s_cyc), 32'h0);
    checkOutput("rst_stall", 32'(cur_stall), 32'h3);
    checkOutput("rst_ack",   32'(cur_ack),   32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_owner", 32'(cur_owner), 32'h0);
    checkOutput("idle_s_cyc", 32'(cur_s_cyc), 32'h0);
    force_ack = 1'b1;
    #1 checkOutput("spur_idle_ack", 32'(cur_ack), 32'h0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    checkOutput("spur_idle_cnt", 32'(u_fp.out_cnt_q), 32'h0);

    // T2: M1 write burst of 8, zero-wait slave
    applyReset();
    slave_lat = 1;
    b0 = m0_acks_seen; b1 = m1_acks_seen; beat_err = 0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 32'h100;
    #1;
    checkOutput("t2_scyc_before", 32'(cur_s_cyc), 32'h0);
    checkOutput("t2_stall_before", 32'(cur_stall[1]), 32'h1);
    @(posedge clk); #1;
    checkOutput("t2_scyc_after", 32'(cur_s_cyc), 32'h1);
    checkOutput("t2_dat_sm", cur_dsm[1], 32'hA5A5_3C3C);
    applyStimulus(1, 8, 1'b1, 32'h100, a1);
    checkOutput("t2_acks", 32'(a1), 32'd8);
    checkOutput("t2_m1_ack_cnt", 32'(m1_acks_seen - b1), 32'd8);
    checkOutput("t2_m0_ack_cnt", 32'(m0_acks_seen - b0), 32'd0);
    checkOutput("t2_beats", 32'(beat_err), 32'd0);

    // T3: fixed priority on a tie, then direct handover without IDLE
    applyReset();
    m_cyc = 2'b11; m_stb = 2'b10;
    @(posedge clk); #1;
    checkOutput("t3_owner_tie", 32'(cur_owner), 32'h1);
    checkOutput("t3_no_fwd", 32'(cur_s_stb), 32'h0);
    checkOutput("t3_m1_stall", 32'(cur_stall[1]), 32'h1);
    s_stall = 1'b1;
    #1 checkOutput("t3_slave_stall", 32'(cur_stall[0]), 32'h1);
    s_stall = 1'b0;
    force_ack = 1'b1;
    #1 checkOutput("t3_spur_ack", 32'(cur_ack), 32'h0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    checkOutput("t3_spur_cnt", 32'(u_fp.out_cnt_q), 32'h0);
    applyStimulus(0, 2, 1'b0, 32'h200, a0);
    checkOutput("t3_acks", 32'(a0), 32'd2);
    @(posedge clk); #1;
    checkOutput("t3_handover", 32'(cur_owner), 32'h2);
    checkOutput("t3_no_bubble", 32'(cur_s_cyc), 32'h1);
    m_cyc = '0; m_stb = '0;

    // T4: round-robin instance, two masters with back-to-back 4-beat bursts
    applyReset();
    use_rr = 1'b1; slave_lat = 1; beat_err = 0;
    rec_en = 1'b1;
    fork
      begin
        applyStimulus(0, 4, 1'b0, 32'h300, a0);
        checkOutput("t4_m0_b1", 32'(a0), 32'd4);
        @(posedge clk); #1;
        applyStimulus(0, 4, 1'b0, 32'h340, a0);
        checkOutput("t4_m0_b2", 32'(a0), 32'd4);
      end
      begin
        applyStimulus(1, 4, 1'b1, 32'h400, a1);
        checkOutput("t4_m1_b1", 32'(a1), 32'd4);
        @(posedge clk); #1;
        applyStimulus(1, 4, 1'b1, 32'h440, a1);
        checkOutput("t4_m1_b2", 32'(a1), 32'd4);
      end
    join
    repeat (2) @(posedge clk);
    #1 rec_en = 1'b0;
    checkOutput("t4_grant_count", 32'(own_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4_grant%0d", i),
                  (i < own_log.size()) ? 32'(own_log[i]) : 32'h0, 32'(exp_g[i]));
    end
    checkOutput("t4_beats", 32'(beat_err), 32'd0);
    applyStimulus(0, 1, 1'b0, 32'h380, a0);
    repeat (2) @(posedge clk);
    #1 m_cyc = 2'b11;
    @(posedge clk); #1;
    checkOutput("t4_rr_tie", 32'(cur_owner), 32'h2);
    m_cyc = '0;

    // T5: OUT_W=2, 5-cycle slave, M0 issues 5 reads and drops cyc early
    applyReset();
    use_rr = 1'b0; slave_lat = 5;
    m_we[0] = 1'b0; m_adr[0] = 32'h500;
    m_cyc = 2'b11; m_stb = 2'b01;
    sent = 0; acks = 0; stall_seen = 0; held_err = 0;
    for (int c = 0; c < 60 && acks < 5; c++) begin
      @(negedge clk);
      if (cur_owner == 2'b01 && m_stb[0] && cur_stall[0] && stall_seen == 0 && sent > 0) begin
        checkOutput("t5_sent_at_stall", 32'(sent), 32'd3);
        stall_seen = 1;
      end
      if (m_stb[0] && !cur_stall[0]) sent++;
      if (cur_ack[0]) acks++;
      if (!m_cyc[0] && (cur_owner != 2'b01 || !cur_s_cyc || !cur_stall[1])) held_err++;
      @(posedge clk); #1;
      if (sent == 5) begin
        m_stb[0] = 1'b0;
        m_cyc[0] = 1'b0;
      end
    end
    checkOutput("t5_stall_seen", 32'(stall_seen), 32'd1);
    checkOutput("t5_acks", 32'(acks), 32'd5);
    checkOutput("t5_held", 32'(held_err), 32'd0);
    checkOutput("t5_owner_last_ack", 32'(cur_owner), 32'h1);
    @(posedge clk); #1;
    checkOutput("t5_m1_granted", 32'(cur_owner), 32'h2);
    m_cyc = '0;

    // T6: reset asserted while two reads are outstanding
    applyReset();
    slave_lat = 5;
    m_adr[0] = 32'h600; m_cyc = 2'b01; m_stb = 2'b01;
    sent = 0;
    for (int c = 0; c < 20 && sent < 2; c++) begin
      @(negedge clk);
      if (m_stb[0] && !cur_stall[0]) sent++;
      @(posedge clk); #1;
      if (sent == 2) m_stb[0] = 1'b0;
    end
    checkOutput("t6_cnt_before", 32'(u_fp.out_cnt_q), 32'd2);
    @(negedge clk);
    rst_n = 1'b0; m_cyc = '0;
    @(posedge clk); #1;
    checkOutput("t6_owner", 32'(cur_owner), 32'h0);
    checkOutput("t6_s_cyc", 32'(cur_s_cyc), 32'h0);
    checkOutput("t6_cnt", 32'(u_fp.out_cnt_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
